// File: rtl/chip8_pkg.sv
// Shared types and opcode constants for the Chip-8 execute unit.
package chip8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Top opcode nibbles
    localparam logic [3:0] OP_SE_K  = 4'h3;
    localparam logic [3:0] OP_SNE_K = 4'h4;
    localparam logic [3:0] OP_SE_R  = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ADD   = 4'h7;
    localparam logic [3:0] OP_ALU   = 4'h8;
    localparam logic [3:0] OP_SNE_R = 4'h9;
    localparam logic [3:0] OP_MISC  = 4'hF;

    // 8xyN sub-operations
    localparam logic [3:0] ALU_MOV  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_ADD  = 4'h4;
    localparam logic [3:0] ALU_SUB  = 4'h5;
    localparam logic [3:0] ALU_SHR  = 4'h6;
    localparam logic [3:0] ALU_SUBN = 4'h7;
    localparam logic [3:0] ALU_SHL  = 4'hE;

    // Fx low bytes for the register-block transfers
    localparam logic [7:0] LD_REGS = 8'h65;
    localparam logic [7:0] ST_REGS = 8'h55;

endpackage

// File: rtl/chip8_exec_unit_if.sv
// Instruction handshake, completion and memory port of the execute unit.
// master = fetch/decode + memory arbiter side, slave = the execute unit.
interface chip8_exec_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instruction;
    logic [ADDR_W-1:0] i_reg;
    logic              done;
    logic              skip;
    logic              illegal;
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output instr_valid, instruction, i_reg, mem_ack, mem_rdata,
        input  instr_ready, done, skip, illegal, i_wr_en, i_wr_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  instr_valid, instruction, i_reg, mem_ack, mem_rdata,
        output instr_ready, done, skip, illegal, i_wr_en, i_wr_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/chip8_regfile.sv
// V-register file: one data write port, a dedicated VF write port that wins
// on collision, and three combinational read ports.
module chip8_regfile #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              vf_wr_en,
    input  logic [DATA_W-1:0] vf_wr_data,
    input  logic [IDX_W-1:0]  rd_x_addr,
    output logic [DATA_W-1:0] rd_x_data,
    input  logic [IDX_W-1:0]  rd_y_addr,
    output logic [DATA_W-1:0] rd_y_data,
    input  logic [IDX_W-1:0]  rd_dbg_addr,
    output logic [DATA_W-1:0] rd_dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Register storage; the VF write comes last so a flag write overrides a result write to VF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (vf_wr_en) begin
                regs[NUM_REGS-1] <= vf_wr_data;
            end
        end
    end

    assign rd_x_data   = regs[rd_x_addr];
    assign rd_y_data   = regs[rd_y_addr];
    assign rd_dbg_data = regs[rd_dbg_addr];

endmodule

// File: rtl/chip8_exec_unit.sv
// Multi-cycle Chip-8 execute unit: ALU/skip ops finish in one EXEC cycle,
// Fx55/Fx65 walk V0..Vx over the req/ack memory port in the MEM state.
module chip8_exec_unit
    import chip8_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int NUM_REGS     = 16,
    parameter int ADDR_W       = 12,
    parameter int LEGACY_SHIFT = 0,
    parameter int I_INCR       = 0,
    localparam int IDX_W       = $clog2(NUM_REGS)
) (
    input  logic              cpu_clk,
    input  logic              reset_n,
    chip8_exec_unit_if.slave  bus,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [15:0]       instr_q;
    logic [ADDR_W-1:0] i_base;
    logic [IDX_W-1:0]  k;

    logic [3:0]        op;
    logic [3:0]        sub_op;
    logic [7:0]        kk;
    logic [IDX_W-1:0]  x_idx;
    logic [IDX_W-1:0]  y_idx;
    logic              is_mem;
    logic              is_store;

    logic [DATA_W-1:0] vx;
    logic [DATA_W-1:0] vy;
    logic [IDX_W-1:0]  rd_b_addr;

    logic [DATA_W-1:0] alu_res;
    logic              alu_we;
    logic              alu_flag_we;
    logic              alu_flag_bit;
    logic              skip_d;
    logic              illegal_d;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] shift_src;

    logic              mem_rd_ack;
    logic              data_we;
    logic [IDX_W-1:0]  data_waddr;
    logic [DATA_W-1:0] data_wdata;
    logic              flag_we;
    logic [DATA_W-1:0] flag_val;

    assign op       = instr_q[15:12];
    assign sub_op   = instr_q[3:0];
    assign kk       = instr_q[7:0];
    assign x_idx    = IDX_W'(instr_q[11:8]);
    assign y_idx    = IDX_W'(instr_q[7:4]);
    assign is_mem   = (op == OP_MISC) && ((kk == ST_REGS) || (kk == LD_REGS));
    assign is_store = (op == OP_MISC) && (kk == ST_REGS);

    assign sum       = {1'b0, vx} + {1'b0, vy};
    assign shift_src = (LEGACY_SHIFT != 0) ? vy : vx;

    // Second read port serves Vy for ALU ops and the next store element during transfers
    always_comb begin
        rd_b_addr = y_idx;
        if (state == EXEC && is_mem) begin
            rd_b_addr = '0;
        end else if (state == MEM) begin
            rd_b_addr = k + 1'b1;
        end
    end

    // Opcode decode and ALU: result, flag, skip and illegal for the latched instruction
    always_comb begin
        alu_res      = '0;
        alu_we       = 1'b0;
        alu_flag_we  = 1'b0;
        alu_flag_bit = 1'b0;
        skip_d       = 1'b0;
        illegal_d    = 1'b0;
        case (op)
            OP_SE_K:  skip_d = (vx == DATA_W'(kk));
            OP_SNE_K: skip_d = (vx != DATA_W'(kk));
            OP_SE_R: begin
                if (sub_op == 4'h0) skip_d = (vx == vy);
                else                illegal_d = 1'b1;
            end
            OP_SNE_R: begin
                if (sub_op == 4'h0) skip_d = (vx != vy);
                else                illegal_d = 1'b1;
            end
            OP_LD: begin
                alu_res = DATA_W'(kk);
                alu_we  = 1'b1;
            end
            OP_ADD: begin
                alu_res = vx + DATA_W'(kk);
                alu_we  = 1'b1;
            end
            OP_ALU: begin
                alu_we = 1'b1;
                case (sub_op)
                    ALU_MOV: alu_res = vy;
                    ALU_OR:  alu_res = vx | vy;
                    ALU_AND: alu_res = vx & vy;
                    ALU_XOR: alu_res = vx ^ vy;
                    ALU_ADD: begin
                        alu_res      = sum[DATA_W-1:0];
                        alu_flag_we  = 1'b1;
                        alu_flag_bit = sum[DATA_W];
                    end
                    ALU_SUB: begin
                        alu_res      = vx - vy;
                        alu_flag_we  = 1'b1;
                        alu_flag_bit = (vx >= vy);
                    end
                    ALU_SUBN: begin
                        alu_res      = vy - vx;
                        alu_flag_we  = 1'b1;
                        alu_flag_bit = (vy >= vx);
                    end
                    ALU_SHR: begin
                        alu_res      = shift_src >> 1;
                        alu_flag_we  = 1'b1;
                        alu_flag_bit = shift_src[0];
                    end
                    ALU_SHL: begin
                        alu_res      = shift_src << 1;
                        alu_flag_we  = 1'b1;
                        alu_flag_bit = shift_src[DATA_W-1];
                    end
                    default: begin
                        alu_we    = 1'b0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            OP_MISC: illegal_d = !is_mem;
            default: illegal_d = 1'b1;
        endcase
    end

    assign mem_rd_ack = (state == MEM) && bus.mem_ack && !bus.mem_we;
    assign data_we    = ((state == EXEC) && alu_we) || mem_rd_ack;
    assign data_waddr = mem_rd_ack ? k : x_idx;
    assign data_wdata = mem_rd_ack ? bus.mem_rdata : alu_res;
    assign flag_we    = (state == EXEC) && alu_flag_we;
    assign flag_val   = {{(DATA_W-1){1'b0}}, alu_flag_bit};

    chip8_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk         (cpu_clk),
        .rst_n       (reset_n),
        .wr_en       (data_we),
        .wr_addr     (data_waddr),
        .wr_data     (data_wdata),
        .vf_wr_en    (flag_we),
        .vf_wr_data  (flag_val),
        .rd_x_addr   (x_idx),
        .rd_x_data   (vx),
        .rd_y_addr   (rd_b_addr),
        .rd_y_data   (vy),
        .rd_dbg_addr (dbg_addr),
        .rd_dbg_data (dbg_data)
    );

    // Control FSM with all handshake and memory-port outputs registered
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            instr_q         <= '0;
            i_base          <= '0;
            k               <= '0;
            bus.instr_ready <= 1'b1;
            bus.done        <= 1'b0;
            bus.skip        <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.i_wr_en     <= 1'b0;
            bus.i_wr_data   <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q         <= bus.instruction;
                        i_base          <= bus.i_reg;
                        bus.instr_ready <= 1'b0;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_mem) begin
                        k             <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= is_store;
                        bus.mem_addr  <= i_base;
                        bus.mem_wdata <= is_store ? vy : '0;
                        state         <= MEM;
                    end else begin
                        bus.done    <= 1'b1;
                        bus.skip    <= skip_d;
                        bus.illegal <= illegal_d;
                        state       <= DONE;
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        if (k == x_idx) begin
                            bus.mem_req <= 1'b0;
                            bus.mem_we  <= 1'b0;
                            bus.done    <= 1'b1;
                            if (I_INCR != 0) begin
                                bus.i_wr_en   <= 1'b1;
                                bus.i_wr_data <= i_base + ADDR_W'(instr_q[11:8]) + ADDR_W'(1);
                            end
                            state <= DONE;
                        end else begin
                            k             <= k + 1'b1;
                            bus.mem_addr  <= bus.mem_addr + 1'b1;
                            bus.mem_wdata <= bus.mem_we ? vy : '0;
                        end
                    end
                end
                DONE: begin
                    bus.done        <= 1'b0;
                    bus.skip        <= 1'b0;
                    bus.illegal     <= 1'b0;
                    bus.i_wr_en     <= 1'b0;
                    bus.instr_ready <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_exec_unit.sv
// Directed testbench for chip8_exec_unit (LEGACY_SHIFT=0, I_INCR=1).
module tb_chip8_exec_unit;

    logic       clk;
    logic       reset_n;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:4095];
    logic [11:0] log_addr [$];
    logic [7:0]  log_data [$];
    logic        log_we   [$];

    chip8_exec_unit_if #(.DATA_W(8), .ADDR_W(12)) bus ();

    chip8_exec_unit #(
        .DATA_W       (8),
        .NUM_REGS     (16),
        .ADDR_W       (12),
        .LEGACY_SHIFT (0),
        .I_INCR       (1)
    ) dut (
        .cpu_clk  (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one instruction; returns at the negedge after the accept edge, then scrambles i_reg
    task automatic issue(input logic [15:0] ins, input logic [11:0] ir);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruction = ins;
        bus.i_reg       = ir;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instruction = 16'h0000;
        bus.i_reg       = 12'h555;
    endtask

    // Wait for done, acting as memory with `stall` idle cycles before each ack
    task automatic run_until_done(input int stall, input int budget, output bit ok, output int cycles);
        int cnt;
        cnt    = 0;
        ok     = 1'b0;
        cycles = 0;
        while (cycles < budget && !ok) begin
            if (bus.done) begin
                ok = 1'b1;
            end else begin
                if (bus.mem_req) begin
                    if (cnt == stall) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem[bus.mem_addr];
                        log_addr.push_back(bus.mem_addr);
                        log_data.push_back(bus.mem_wdata);
                        log_we.push_back(bus.mem_we);
                        cnt = 0;
                    end else begin
                        bus.mem_ack = 1'b0;
                        cnt++;
                    end
                end else begin
                    bus.mem_ack = 1'b0;
                    cnt = 0;
                end
                @(negedge clk);
                cycles++;
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic peek(input int idx, output logic [7:0] v);
        dbg_addr = idx[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic load_reg(input logic [3:0] x, input logic [7:0] val);
        bit ok;
        int cyc;
        issue({4'h6, x, val}, 12'h000);
        run_until_done(0, 20, ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL load_reg_timeout: got done=0 expected done=1 within 20 cycles");
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int nonzero;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", bus.instr_ready);
        end
        checks++;
        if ({bus.done, bus.skip, bus.illegal, bus.i_wr_en, bus.mem_req, bus.mem_we} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {bus.done, bus.skip, bus.illegal, bus.i_wr_en, bus.mem_req, bus.mem_we});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.i_wr_data} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_buses: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.i_wr_data});
        end
        nonzero = 0;
        for (int i = 0; i < 16; i++) begin
            peek(i, v);
            if (v !== 8'h00) nonzero++;
        end
        checks++;
        if (nonzero != 0) begin
            errors++;
            $display("[TB] FAIL reset_vregs: got %0d nonzero regs expected 0", nonzero);
        end
    endtask

    task automatic test_ld_add();
        logic [7:0] v;
        logic [15:0] prog [2];
        logic [7:0]  exp_a [2];
        prog[0] = 16'h6A3C; exp_a[0] = 8'h3C;
        prog[1] = 16'h7AF0; exp_a[1] = 8'h2C;
        for (int n = 0; n < 2; n++) begin
            issue(prog[n], 12'h000);
            checks++;
            if (bus.done !== 1'b0 || bus.instr_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ld_add_e0_%0d: got done=%b ready=%b expected 0 0", n, bus.done, bus.instr_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ld_add_done_%0d: got %b expected 1", n, bus.done);
            end
            peek(10, v);
            checks++;
            if (v !== exp_a[n]) begin
                errors++;
                $display("[TB] FAIL ld_add_va_%0d: got %h expected %h", n, v, exp_a[n]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ld_add_e2_%0d: got done=%b ready=%b expected 0 1", n, bus.done, bus.instr_ready);
            end
        end
        peek(15, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL add_vf_untouched: got %h expected 00", v);
        end
    endtask

    task automatic test_alu_flags();
        logic [7:0] v1, vf;
        bit ok;
        int cyc;
        load_reg(4'h1, 8'hF0);
        load_reg(4'h2, 8'h20);
        issue(16'h8124, 12'h000);
        run_until_done(0, 20, ok, cyc);
        peek(1, v1);
        peek(15, vf);
        checks++;
        if (!ok || v1 !== 8'h10 || vf !== 8'h01) begin
            errors++;
            $display("[TB] FAIL add_carry: got V1=%h VF=%h expected V1=10 VF=01", v1, vf);
        end
        load_reg(4'h1, 8'h10);
        issue(16'h8125, 12'h000);
        run_until_done(0, 20, ok, cyc);
        peek(1, v1);
        peek(15, vf);
        checks++;
        if (!ok || v1 !== 8'hF0 || vf !== 8'h00) begin
            errors++;
            $display("[TB] FAIL sub_borrow: got V1=%h VF=%h expected V1=F0 VF=00", v1, vf);
        end
        load_reg(4'hF, 8'h81);
        issue(16'h8FF6, 12'h000);
        run_until_done(0, 20, ok, cyc);
        peek(15, vf);
        checks++;
        if (!ok || vf !== 8'h01) begin
            errors++;
            $display("[TB] FAIL shr_vf_override: got VF=%h expected 01", vf);
        end
    endtask

    task automatic test_store_wrap();
        logic [11:0] exp_addr [4];
        logic [7:0]  exp_data [4];
        bit ok;
        int cyc;
        int bad;
        exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
        exp_data[0] = 8'h11;   exp_data[1] = 8'h22;   exp_data[2] = 8'h33;   exp_data[3] = 8'h44;
        load_reg(4'h0, 8'h11);
        load_reg(4'h1, 8'h22);
        load_reg(4'h2, 8'h33);
        load_reg(4'h3, 8'h44);
        log_addr.delete(); log_data.delete(); log_we.delete();
        issue(16'hF355, 12'hFFE);
        run_until_done(2, 60, ok, cyc);
        checks++;
        if (!ok || log_addr.size() != 4) begin
            errors++;
            $display("[TB] FAIL store_count: got %0d writes done=%b expected 4 done=1", log_addr.size(), ok);
        end else begin
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i] || log_we[i] !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL store_order: got %0d bad elements (first %h:%h) expected FFE:11 FFF:22 000:33 001:44",
                         bad, log_addr[0], log_data[0]);
            end
        end
        checks++;
        if (bus.i_wr_en !== 1'b1 || bus.i_wr_data !== 12'h002) begin
            errors++;
            $display("[TB] FAIL store_i_incr: got en=%b data=%h expected en=1 data=002", bus.i_wr_en, bus.i_wr_data);
        end
        log_addr.delete(); log_data.delete(); log_we.delete();
        issue(16'hF055, 12'h300);
        run_until_done(0, 20, ok, cyc);
        checks++;
        if (!ok || log_addr.size() != 1 || log_addr[0] !== 12'h300 || log_data[0] !== 8'h11) begin
            errors++;
            $display("[TB] FAIL store_x0: got %0d writes expected 1 write 300:11", log_addr.size());
        end
        checks++;
        if (bus.i_wr_data !== 12'h301) begin
            errors++;
            $display("[TB] FAIL store_x0_i: got %h expected 301", bus.i_wr_data);
        end
    endtask

    task automatic test_load_ack_high();
        logic [7:0] v;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h05; exp_v[1] = 8'h06; exp_v[2] = 8'h07;
        mem[12'h100] = 8'h05;
        mem[12'h101] = 8'h06;
        mem[12'h102] = 8'h07;
        bus.mem_ack = 1'b1;
        issue(16'hF265, 12'h100);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h100) begin
            errors++;
            $display("[TB] FAIL load_first_req: got req=%b we=%b addr=%h expected 1 0 100",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.mem_rdata = mem[bus.mem_addr];
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            peek(e, v);
            checks++;
            if (v !== exp_v[e]) begin
                errors++;
                $display("[TB] FAIL load_v%0d: got %h expected %h", e, v, exp_v[e]);
            end
            if (e < 2) begin
                peek(e + 1, v);
                checks++;
                if (v === exp_v[e+1]) begin
                    errors++;
                    $display("[TB] FAIL load_early_v%0d: got %h expected not yet written", e + 1, v);
                end
            end
            checks++;
            if (bus.done !== (e == 2)) begin
                errors++;
                $display("[TB] FAIL load_done_e%0d: got %b expected %b", e, bus.done, (e == 2));
            end
            bus.mem_rdata = mem[bus.mem_addr];
        end
        checks++;
        if (bus.i_wr_en !== 1'b1 || bus.i_wr_data !== 12'h103) begin
            errors++;
            $display("[TB] FAIL load_i_incr: got en=%b data=%h expected en=1 data=103", bus.i_wr_en, bus.i_wr_data);
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_skip_illegal();
        logic [7:0] v;
        bit ok;
        int cyc;
        load_reg(4'hA, 8'h2C);
        issue(16'h3A2C, 12'h000);
        run_until_done(0, 20, ok, cyc);
        checks++;
        if (!ok || bus.skip !== 1'b1 || bus.illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skip_eq: got skip=%b illegal=%b expected 1 0", bus.skip, bus.illegal);
        end
        issue(16'h4A2C, 12'h000);
        run_until_done(0, 20, ok, cyc);
        checks++;
        if (!ok || bus.skip !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skip_ne: got skip=%b expected 0", bus.skip);
        end
        issue(16'hE000, 12'h000);
        run_until_done(0, 20, ok, cyc);
        checks++;
        if (!ok || bus.illegal !== 1'b1 || bus.i_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_flag: got illegal=%b i_wr_en=%b expected 1 0", bus.illegal, bus.i_wr_en);
        end
        peek(10, v);
        checks++;
        if (v !== 8'h2C) begin
            errors++;
            $display("[TB] FAIL illegal_no_effect: got VA=%h expected 2C", v);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] v;
        int nonzero;
        load_reg(4'h0, 8'h11);
        load_reg(4'h1, 8'h22);
        load_reg(4'h2, 8'h33);
        load_reg(4'h3, 8'h44);
        bus.mem_ack = 1'b0;
        issue(16'hF355, 12'h200);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h201 || bus.mem_wdata !== 8'h22) begin
            errors++;
            $display("[TB] FAIL midrst_second_elem: got req=%b addr=%h data=%h expected 1 201 22",
                     bus.mem_req, bus.mem_addr, bus.mem_wdata);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h000 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_async: got req=%b we=%b addr=%h ready=%b expected 0 0 000 1",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.instr_ready);
        end
        nonzero = 0;
        for (int i = 0; i < 16; i++) begin
            peek(i, v);
            if (v !== 8'h00) nonzero++;
        end
        checks++;
        if (nonzero != 0) begin
            errors++;
            $display("[TB] FAIL midrst_vregs: got %0d nonzero regs expected 0", nonzero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_release: got ready=%b req=%b expected 1 0", bus.instr_ready, bus.mem_req);
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instruction = 16'h0000;
        bus.i_reg       = 12'h000;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 8'h00;
        dbg_addr        = 4'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_ld_add();
        test_alu_flags();
        test_store_wrap();
        test_load_ack_high();
        test_skip_illegal();
        test_reset_mid_transfer();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
